// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// blank pattern and index-width helper.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Entry n is the {g,f,e,d,c,b,a} glyph for hex digit n (entry 0 in the LSBs).
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex digit to seven-segment glyph lookup (active-high segments).
module hex_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup of the glyph for the selected digit.
    always_comb begin
        seg = GLYPH_TABLE[digit];
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed multi-digit hex display driver with frame-aligned updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = idx_width(CLK_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic                    frame_tick_r;
    logic [4*NUM_DIGITS-1:0] pend_val_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r;
    logic                    pending_r;
    logic [4*NUM_DIGITS-1:0] shadow_val_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   an_r;

    logic                    slot_end_s;
    logic                    wrap_s;
    logic [3:0]              digit_s;
    logic                    dp_sel_s;
    logic [NUM_DIGITS-1:0]   an_s;
    logic                    blank_s;
    logic [6:0]              glyph_s;
    logic [6:0]              seg_next_s;

    // Slot-end and frame-wrap detection.
    always_comb begin
        slot_end_s = (cnt_r == LAST_CNT);
        wrap_s     = slot_end_s && (idx_r == LAST_IDX);
    end

    // Prescaler, digit index and frame tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r        <= {CNT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= wrap_s;
            if (slot_end_s) begin
                cnt_r <= {CNT_W{1'b0}};
                idx_r <= wrap_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Load holding register and frame-boundary shadow transfer; a load on the
    // wrap edge bypasses the holding register so nothing is left pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_val_r   <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pending_r    <= 1'b0;
            shadow_val_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r  <= {NUM_DIGITS{1'b0}};
        end else if (wrap_s) begin
            pending_r <= 1'b0;
            if (load) begin
                shadow_val_r <= value;
                shadow_dp_r  <= dp_in;
            end else if (pending_r) begin
                shadow_val_r <= pend_val_r;
                shadow_dp_r  <= pend_dp_r;
            end else begin
                shadow_val_r <= shadow_val_r;
            end
        end else if (load) begin
            pend_val_r <= value;
            pend_dp_r  <= dp_in;
            pending_r  <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Active-digit mux, one-hot enable and leading-zero blank decision.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic zero_above_s;
        zero_above_s = 1'b1;
`endif
        digit_s  = 4'h0;
        dp_sel_s = 1'b0;
        an_s     = {NUM_DIGITS{1'b0}};
        blank_s  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
            zero_above_s = zero_above_s && (shadow_val_r[4*i +: 4] == 4'h0);
`endif
            if (idx_r == IDX_W'(i)) begin
                digit_s  = shadow_val_r[4*i +: 4];
                dp_sel_s = shadow_dp_r[i];
                an_s[i]  = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                blank_s  = zero_above_s && !shadow_dp_r[i] && (i != 0);
`else
                blank_s  = 1'b0;
`endif
            end else begin
                an_s[i] = 1'b0;
            end
        end
        seg_next_s = blank_s ? SEG_OFF : glyph_s;
    end

    hex_seg_decode u_decode (
        .digit (digit_s),
        .seg   (glyph_s)
    );

    // Output flops with polarity applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_r <= SEG_OFF ^ {7{POL}};
            dp_r  <= POL;
            an_r  <= {NUM_DIGITS{POL}};
        end else begin
            seg_r <= seg_next_s ^ {7{POL}};
            dp_r  <= dp_sel_s ^ POL;
            an_r  <= an_s ^ {NUM_DIGITS{POL}};
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign frame_tick = frame_tick_r;
    assign pending    = pending_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: an active-high and an active-low instance share stimulus;
// expected frames are queued at load time and compared when they are displayed.
module tb_seven_seg_scan_driver;

    typedef struct packed {
        logic [3:0][6:0] segs;
        logic [3:0]      dps;
    } exp_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        exp_t        exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [15:0] value_s;
    logic [3:0]  dp_in_s;
    logic        load_s;
    logic [6:0]  seg, seg_al;
    logic        dp, dp_al;
    logic [3:0]  an, an_al;
    logic        frame_tick, frame_tick_al;
    logic        pending, pending_al;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    vec_t vecs[6];

    seven_seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(0)) dut (
        .clk(clk), .reset(reset), .value(value_s), .dp_in(dp_in_s), .load(load_s),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick), .pending(pending)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .reset(reset), .value(value_s), .dp_in(dp_in_s), .load(load_s),
        .seg(seg_al), .dp(dp_al), .an(an_al), .frame_tick(frame_tick_al),
        .pending(pending_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0,
                                input logic [3:0] d);
        exp_t e;
        e.segs = {s3, s2, s1, s0};
        e.dps  = d;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value_s = v;
        dp_in_s = d;
        load_s  = 1'b1;
        @(negedge clk);
        load_s  = 1'b0;
        chk("pending_set", {31'd0, pending}, 32'd1);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 40);
        chk("tick_timeout", {31'd0, frame_tick}, 32'd1);
        chk("pending_clear", {31'd0, pending}, 32'd0);
    endtask

    // Call at the negedge just before the frame starts; compares all 16 cycles.
    task automatic check_frame();
        exp_t       e;
        logic [3:0] ean;
        logic [6:0] nseg;
        int         d;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            d    = j / 4;
            ean  = 4'b0001 << d;
            nseg = ~e.segs[d];
            chk("an", {28'd0, an}, {28'd0, ean});
            chk("seg", {25'd0, seg}, {25'd0, e.segs[d]});
            chk("dp", {31'd0, dp}, {31'd0, e.dps[d]});
            chk("an_al", {28'd0, an_al}, {28'd0, ~ean});
            chk("seg_al", {25'd0, seg_al}, {25'd0, nseg});
            chk("dp_al", {31'd0, dp_al}, {31'd0, ~e.dps[d]});
            chk("frame_tick", {31'd0, frame_tick}, (j == 15) ? 32'd1 : 32'd0);
            if (j == 0) begin
                chk("pending_idle", {31'd0, pending}, 32'd0);
            end
        end
    endtask

    task automatic check_off();
        chk("off_seg", {25'd0, seg}, 32'h00);
        chk("off_dp", {31'd0, dp}, 32'd0);
        chk("off_an", {28'd0, an}, 32'h0);
        chk("off_seg_al", {25'd0, seg_al}, 32'h7F);
        chk("off_dp_al", {31'd0, dp_al}, 32'd1);
        chk("off_an_al", {28'd0, an_al}, 32'hF);
        chk("off_tick", {31'd0, frame_tick}, 32'd0);
        chk("off_pending", {31'd0, pending}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'hF8A1, 4'b0000, mk(7'h71, 7'h7F, 7'h77, 7'h06, 4'b0000)};
        vecs[1] = '{16'h3210, 4'b0100, mk(7'h4F, 7'h5B, 7'h06, 7'h3F, 4'b0100)};
        vecs[2] = '{16'h7654, 4'b1001, mk(7'h07, 7'h7D, 7'h6D, 7'h66, 4'b1001)};
        vecs[3] = '{16'hEDCB, 4'b0010, mk(7'h79, 7'h5E, 7'h39, 7'h7C, 4'b0010)};
        vecs[4] = '{16'h8889, 4'b0000, mk(7'h7F, 7'h7F, 7'h7F, 7'h6F, 4'b0000)};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[5] = '{16'h0030, 4'b0000, mk(7'h00, 7'h00, 7'h4F, 7'h3F, 4'b0000)};
`else
        vecs[5] = '{16'h0030, 4'b0000, mk(7'h3F, 7'h3F, 7'h4F, 7'h3F, 4'b0000)};
`endif

        reset   = 1'b1;
        value_s = 16'h0000;
        dp_in_s = 4'b0000;
        load_s  = 1'b0;
        #12;
        check_off();
        @(negedge clk);
        reset = 1'b0;
        sb_q.push_back(mk(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000));
        check_frame();

        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i].value, vecs[i].dp);
            sb_q.push_back(vecs[i].exp);
            wait_tick();
            check_frame();
        end

        // Two loads in one frame: only the last is ever shown.
        do_load(16'h1111, 4'b0000);
        repeat (3) @(negedge clk);
        do_load(16'h2222, 4'b0000);
        sb_q.push_back(mk(7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b0000));
        wait_tick();
        check_frame();

        // Load coinciding with the wrap edge goes straight to the shadow.
        repeat (15) @(negedge clk);
        value_s = 16'h000E;
        dp_in_s = 4'b0000;
        load_s  = 1'b1;
        @(negedge clk);
        load_s  = 1'b0;
        chk("wrap_load_pending", {31'd0, pending}, 32'd0);
        chk("wrap_load_tick", {31'd0, frame_tick}, 32'd1);
        sb_q.push_back(mk(7'h3F, 7'h3F, 7'h3F, 7'h79, 4'b0000));
        check_frame();

        // Asynchronous reset mid-slot with a load pending: outputs off at once, data lost.
        do_load(16'hF8A1, 4'b1111);
        #2;
        reset = 1'b1;
        #1;
        check_off();
        @(negedge clk);
        reset = 1'b0;
        sb_q.push_back(mk(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000));
        check_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
